// File: rtl/train_index_counter.sv
// -----------------------------------------------------------------------------
// train_index_counter
//
// Purpose: Generates the sample index for a training loop. After start, every
// accepted step advances the index modulo WRAP_VAL, counts completed epochs
// and accepted steps, and stops in DONE after MAX_ITER steps.
//
// Optional feature: define TRAIN_IDX_LOAD_EN to enable loading the index from
// i_data_in while running. Without it, i_load and i_data_in are ignored.
//
// Ports:
//   i_clk         rising-edge clock
//   i_rst_n       asynchronous active-low reset
//   i_clr         synchronous clear to IDLE (highest priority)
//   i_start       begin a run (IDLE/DONE only)
//   i_step        advance index by one (RUN only)
//   i_load        load index from i_data_in (RUN only, TRAIN_IDX_LOAD_EN)
//   i_data_in     index value to load
//   o_data_out    current sample index
//   o_epoch       completed-epoch count
//   o_iter        accepted-step count
//   o_idx_valid   one-cycle pulse when the index changed by step or load
//   o_wrap        one-cycle pulse when the index wrapped to 0 by step
//   o_busy        high in RUN
//   o_done        high in DONE
// -----------------------------------------------------------------------------
module train_index_counter #(
  parameter int unsigned IDX_W    = 16,
  parameter int unsigned WRAP_VAL = 332,
  parameter int unsigned MAX_ITER = 10000,
  parameter int unsigned ITER_W   = 17,
  parameter int unsigned EPOCH_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_start,
  input  logic               i_step,
  input  logic               i_load,
  input  logic [IDX_W-1:0]   i_data_in,
  output logic [IDX_W-1:0]   o_data_out,
  output logic [EPOCH_W-1:0] o_epoch,
  output logic [ITER_W-1:0]  o_iter,
  output logic               o_idx_valid,
  output logic               o_wrap,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(WRAP_VAL - 1);
  localparam logic [IDX_W-1:0]  WrapIdx  = IDX_W'(WRAP_VAL);
  localparam logic [ITER_W-1:0] LastIter = ITER_W'(MAX_ITER - 1);

  state_e             r_state, w_state_d;
  logic [IDX_W-1:0]   r_idx, w_idx_d;
  logic [EPOCH_W-1:0] r_epoch, w_epoch_d;
  logic [ITER_W-1:0]  r_iter, w_iter_d;
  logic               r_valid, w_valid_d;
  logic               r_wrap, w_wrap_d;
  logic               r_busy, w_busy_d;
  logic               r_done, w_done_d;

`ifndef TRAIN_IDX_LOAD_EN
  // Load path compiled out; keep the ports referenced so they read as intentional.
  logic w_unused_load;
  assign w_unused_load = ^{i_load, i_data_in};
`endif

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_epoch_d = r_epoch;
    w_iter_d  = r_iter;
    w_valid_d = 1'b0;
    w_wrap_d  = 1'b0;

    if (i_clr) begin
      w_state_d = StIdle;
      w_idx_d   = '0;
      w_epoch_d = '0;
      w_iter_d  = '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            w_state_d = StRun;
            w_idx_d   = '0;
            w_epoch_d = '0;
            w_iter_d  = '0;
          end
        end
        StRun: begin
`ifdef TRAIN_IDX_LOAD_EN
          // Load wins over a simultaneous step; out-of-range values land on 0.
          if (i_load) begin
            w_idx_d   = (i_data_in < WrapIdx) ? i_data_in : '0;
            w_valid_d = 1'b1;
          end else
`endif
          if (i_step) begin
            w_valid_d = 1'b1;
            w_iter_d  = r_iter + ITER_W'(1);
            if (r_idx == LastIdx) begin
              w_idx_d   = '0;
              w_epoch_d = r_epoch + EPOCH_W'(1);
              w_wrap_d  = 1'b1;
            end else begin
              w_idx_d = r_idx + IDX_W'(1);
            end
            // The final step still applies; the run ends on the same edge.
            if (r_iter == LastIter) begin
              w_state_d = StDone;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end

    w_busy_d = (w_state_d == StRun);
    w_done_d = (w_state_d == StDone);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_epoch <= '0;
      r_iter  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_epoch <= w_epoch_d;
      r_iter  <= w_iter_d;
      r_valid <= w_valid_d;
      r_wrap  <= w_wrap_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  assign o_data_out  = r_idx;
  assign o_epoch     = r_epoch;
  assign o_iter      = r_iter;
  assign o_idx_valid = r_valid;
  assign o_wrap      = r_wrap;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_train_index_counter.sv
// -----------------------------------------------------------------------------
// tb_train_index_counter
//
// Self-checking bench for train_index_counter with WRAP_VAL=4, MAX_ITER=10.
// Directed scenarios compare against literal expectations; the random scenario
// compares against a behavioural model of the run/epoch/iteration rules.
// Follows TRAIN_IDX_LOAD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_train_index_counter;

  localparam int Wrap    = 4;
  localparam int MaxIter = 10;
`ifdef TRAIN_IDX_LOAD_EN
  localparam bit LoadEn = 1'b1;
`else
  localparam bit LoadEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        clr, start, step, load;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [7:0]  epoch;
  logic [16:0] iter;
  logic        idx_valid, wrap, busy, done;

  // {data_out, epoch, iter, idx_valid, wrap, busy, done}
  logic [44:0] obs;
  assign obs = {data_out, epoch, iter, idx_valid, wrap, busy, done};

  int n_vec;
  int n_err;

  // Behavioural model: phase 0 idle, 1 running, 2 finished.
  int m_phase, m_idx, m_epoch, m_iter;
  bit m_valid, m_wrap;

  train_index_counter #(
    .IDX_W   (16),
    .WRAP_VAL(Wrap),
    .MAX_ITER(MaxIter),
    .ITER_W  (17),
    .EPOCH_W (8)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clr      (clr),
    .i_start    (start),
    .i_step     (step),
    .i_load     (load),
    .i_data_in  (data_in),
    .o_data_out (data_out),
    .o_epoch    (epoch),
    .o_iter     (iter),
    .o_idx_valid(idx_valid),
    .o_wrap     (wrap),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  function automatic logic [44:0] pack(int d, int e, int it, bit v, bit w, bit b, bit dn);
    return {16'(d), 8'(e), 17'(it), v, w, b, dn};
  endfunction

  function automatic logic [44:0] model_vec();
    return pack(m_idx, m_epoch, m_iter, m_valid, m_wrap, m_phase == 1, m_phase == 2);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_epoch = 0; m_iter = 0; m_valid = 0; m_wrap = 0;
  endtask

  task automatic model_edge(bit c, bit s, bit st, bit l, int d);
    m_valid = 0;
    m_wrap  = 0;
    if (c) begin
      m_phase = 0; m_idx = 0; m_epoch = 0; m_iter = 0;
    end else if (m_phase != 1) begin
      if (s) begin
        m_phase = 1; m_idx = 0; m_epoch = 0; m_iter = 0;
      end
    end else if (LoadEn && l) begin
      m_idx   = (d < Wrap) ? d : 0;
      m_valid = 1;
    end else if (st) begin
      m_valid = 1;
      m_iter  = m_iter + 1;
      m_idx   = (m_idx + 1) % Wrap;
      if (m_idx == 0) begin
        m_wrap  = 1;
        m_epoch = (m_epoch + 1) % 256;
      end
      if (m_iter == MaxIter) m_phase = 2;
    end
  endtask

  // Apply one cycle of inputs; return 1ns after the edge with the model updated.
  task automatic drive(bit c, bit s, bit st, bit l, int d);
    clr = c; start = s; step = st; load = l; data_in = 16'(d);
    @(posedge clk);
    #1;
    model_edge(c, s, st, l, d);
  endtask

  task automatic test_reset();
    clr = 0; start = 0; step = 0; load = 0; data_in = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (obs !== pack(0, 0, 0, 0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 0, 0));
    end
    rst_n = 1'b1;
    drive(0, 0, 1, 1, 2);
    n_vec++;
    if (obs !== pack(0, 0, 0, 0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL idle_ignores_step: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_run_sequence();
    logic [44:0] e;
    drive(0, 1, 0, 0, 0);
    n_vec++;
    if (obs !== pack(0, 0, 0, 0, 0, 1, 0)) begin
      n_err++;
      $display("FAIL start: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 1, 0));
    end
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 1, 0, 0);
      e = pack(k % 4, k / 4, k, 1, (k % 4) == 0, k < 10, k == 10);
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL run_step_%0d: got %h expected %h", k, obs, e);
      end
    end
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== pack(2, 2, 10, 0, 0, 0, 1)) begin
      n_err++;
      $display("FAIL done_pulses_clear: got %h expected %h", obs, pack(2, 2, 10, 0, 0, 0, 1));
    end
  endtask

  task automatic test_done_hold();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, k == 1, 1);
      n_vec++;
      if (obs !== pack(2, 2, 10, 0, 0, 0, 1)) begin
        n_err++;
        $display("FAIL done_hold_%0d: got %h expected %h", k, obs, pack(2, 2, 10, 0, 0, 0, 1));
      end
    end
    drive(0, 1, 0, 0, 0);
    n_vec++;
    if (obs !== pack(0, 0, 0, 0, 0, 1, 0)) begin
      n_err++;
      $display("FAIL done_restart: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 1, 0));
    end
  endtask

  task automatic test_async_reset();
    repeat (5) drive(0, 0, 1, 0, 0);
    n_vec++;
    if (obs !== pack(1, 1, 5, 1, 0, 1, 0)) begin
      n_err++;
      $display("FAIL pre_reset_iter5: got %h expected %h", obs, pack(1, 1, 5, 1, 0, 1, 0));
    end
    // Mid-cycle, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (obs !== pack(0, 0, 0, 0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 0, 0));
    end
    #1 rst_n = 1'b1;
    drive(0, 0, 1, 0, 0);
    n_vec++;
    if (obs !== pack(0, 0, 0, 0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL resume_idle: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_clr();
    drive(0, 1, 0, 0, 0);
    repeat (3) drive(0, 0, 1, 0, 0);
    n_vec++;
    if (obs !== pack(3, 0, 3, 1, 0, 1, 0)) begin
      n_err++;
      $display("FAIL pre_clr: got %h expected %h", obs, pack(3, 0, 3, 1, 0, 1, 0));
    end
    drive(1, 1, 1, 1, 2);
    n_vec++;
    if (obs !== pack(0, 0, 0, 0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL clr_priority: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_load();
    logic [44:0] e;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 2);
    e = LoadEn ? pack(2, 0, 1, 1, 0, 1, 0) : pack(1, 0, 1, 0, 0, 1, 0);
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL load_in_range: got %h expected %h", obs, e);
    end
    drive(0, 0, 0, 1, 4);
    e = LoadEn ? pack(0, 0, 1, 1, 0, 1, 0) : pack(1, 0, 1, 0, 0, 1, 0);
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL load_out_of_range: got %h expected %h", obs, e);
    end
    drive(0, 0, 1, 1, 3);
    e = LoadEn ? pack(3, 0, 1, 1, 0, 1, 0) : pack(2, 0, 2, 1, 0, 1, 0);
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL load_beats_step: got %h expected %h", obs, e);
    end
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL load_hold: got %h expected %h", obs, model_vec());
    end
  endtask

  task automatic test_random();
    bit c, s, st, l;
    int d;
    for (int i = 0; i < 500; i++) begin
      c  = ($urandom_range(0, 19) == 0);
      s  = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 1) == 1);
      l  = ($urandom_range(0, 5) == 0);
      d  = $urandom_range(0, 7);
      drive(c, s, st, l, d);
      n_vec++;
      if (obs !== model_vec()) begin
        n_err++;
        $display("FAIL random_%0d: got %h expected %h", i, obs, model_vec());
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_run_sequence();
    test_done_hold();
    test_async_reset();
    test_clr();
    test_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
